// File: rtl/omega8_pkg.sv
// Shared types and constants for the omega8 execute stage: widths, opcodes,
// flag bit positions and sequencing states.
package omega8_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SHL = 4'd5,
    OP_SHR = 4'd6,
    OP_MOV = 4'd7,
    OP_CMP = 4'd8,
    OP_LDI = 4'd9
  } opcode_e;

  // o_flags is packed {N,C,Z}
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_e;

  // ALU ops plus CMP update the flags; MOV, LDI and the NOP range leave them alone.
  function automatic logic sets_flags(input logic [3:0] op);
    return (op <= OP_SHR) || (op == OP_CMP);
  endfunction

  function automatic logic writes_rd(input logic [3:0] op);
    return (op <= OP_LDI) && (op != OP_CMP);
  endfunction

endpackage

// File: rtl/alu8.sv
// Combinational 8-bit ALU: result and carry for one opcode.
module alu8
  import omega8_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  input  logic [3:0]        opcode,
  output logic [DATA_W-1:0] result,
  output logic              c
);

  always_comb begin
    result = '0;
    c      = 1'b0;
    case (opcode)
      OP_ADD: {c, result} = {1'b0, a} + {1'b0, b};
      OP_SUB, OP_CMP: begin
        result = a - b;
        c      = (a < b);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: begin
        result = {a[DATA_W-2:0], 1'b0};
        c      = a[DATA_W-1];
      end
      OP_SHR: begin
        result = {1'b0, a[DATA_W-1:1]};
        c      = a[0];
      end
      OP_MOV: result = a;
      OP_LDI: result = imm;
      default: begin
        result = '0;
        c      = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/exec_stage.sv
// Four-cycle execute stage: accept, read operands from the register file,
// execute through alu8, then write back and retire.
module exec_stage
  import omega8_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [3:0]        i_opcode,
  input  logic [ADDR_W-1:0] i_rd,
  input  logic [ADDR_W-1:0] i_rs1,
  input  logic [ADDR_W-1:0] i_rs2,
  input  logic [DATA_W-1:0] i_imm,
  output logic [ADDR_W-1:0] o_rf_r_address1,
  output logic [ADDR_W-1:0] o_rf_r_address2,
  input  logic [DATA_W-1:0] i_rf_data1,
  input  logic [DATA_W-1:0] i_rf_data2,
  output logic [ADDR_W-1:0] o_rf_w_address,
  output logic [DATA_W-1:0] o_rf_data,
  output logic              o_rf_write,
  output logic [2:0]        o_flags,
  output logic              o_done
);

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [ADDR_W-1:0] ra1_q, ra1_d;
  logic [ADDR_W-1:0] ra2_q, ra2_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        flags_q, flags_d;
  logic              ready_q, ready_d;
  logic              wr_q, wr_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] alu_res;
  logic              alu_c;

  alu8 u_alu (
    .a      (i_rf_data1),
    .b      (i_rf_data2),
    .imm    (imm_q),
    .opcode (op_q),
    .result (alu_res),
    .c      (alu_c)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    ra1_d   = ra1_q;
    ra2_d   = ra2_q;
    waddr_d = waddr_q;
    imm_d   = imm_q;
    wdata_d = wdata_q;
    flags_d = flags_q;
    ready_d = ready_q;
    wr_d    = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_valid && ready_q) begin
          op_d    = i_opcode;
          rd_d    = i_rd;
          ra1_d   = i_rs1;
          ra2_d   = i_rs2;
          imm_d   = i_imm;
          ready_d = 1'b0;
          state_d = S_READ;
        end
      end
      S_READ: state_d = S_EXEC;
      // Register-file data for the READ addresses is valid now; wr/done
      // are set up here so they appear as registered pulses during WB.
      S_EXEC: begin
        waddr_d = rd_q;
        wdata_d = alu_res;
        wr_d    = writes_rd(op_q);
        done_d  = 1'b1;
        if (sets_flags(op_q)) begin
          flags_d[FLAG_N] = alu_res[DATA_W-1];
          flags_d[FLAG_C] = alu_c;
          flags_d[FLAG_Z] = (alu_res == '0);
        end
        state_d = S_WB;
      end
      S_WB: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      ra1_q   <= '0;
      ra2_q   <= '0;
      waddr_q <= '0;
      imm_q   <= '0;
      wdata_q <= '0;
      flags_q <= '0;
      ready_q <= 1'b1;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      ra1_q   <= ra1_d;
      ra2_q   <= ra2_d;
      waddr_q <= waddr_d;
      imm_q   <= imm_d;
      wdata_q <= wdata_d;
      flags_q <= flags_d;
      ready_q <= ready_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
    end
  end

  assign o_ready         = ready_q;
  assign o_rf_r_address1 = ra1_q;
  assign o_rf_r_address2 = ra2_q;
  assign o_rf_w_address  = waddr_q;
  assign o_rf_data       = wdata_q;
  assign o_rf_write      = wr_q;
  assign o_flags         = flags_q;
  assign o_done          = done_q;

endmodule

// File: tb/tb_exec_stage.sv
// Scoreboard bench for exec_stage with a registered-read register-file model.
module tb_exec_stage;
  import omega8_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic       ready;
  logic [3:0] opcode;
  logic [2:0] rd, rs1, rs2;
  logic [7:0] imm;
  logic [2:0] raddr1, raddr2, waddr;
  logic [7:0] rdata1, rdata2, wdata;
  logic       wr;
  logic [2:0] flags;
  logic       done;

  always #5 clk = ~clk;

  exec_stage dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_valid         (valid),
    .o_ready         (ready),
    .i_opcode        (opcode),
    .i_rd            (rd),
    .i_rs1           (rs1),
    .i_rs2           (rs2),
    .i_imm           (imm),
    .o_rf_r_address1 (raddr1),
    .o_rf_r_address2 (raddr2),
    .i_rf_data1      (rdata1),
    .i_rf_data2      (rdata2),
    .o_rf_w_address  (waddr),
    .o_rf_data       (wdata),
    .o_rf_write      (wr),
    .o_flags         (flags),
    .o_done          (done)
  );

  // Register file: one-cycle registered read, preloaded r1=0x7F, r2=0x01.
  logic [7:0] rf [8];
  logic       rf_load;
  always @(posedge clk) begin
    if (rf_load) begin
      for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
      rf[1] <= 8'h7F;
      rf[2] <= 8'h01;
    end else if (wr) begin
      rf[waddr] <= wdata;
    end
    rdata1 <= rf[raddr1];
    rdata2 <= rf[raddr2];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       wr;
    logic [2:0] addr;
    logic [7:0] data;
    logic [2:0] flags;
    int         cyc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   last_acc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every retirement pops one expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got o_done=1 at cycle %0d, expected no retirement", cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("wb_write", 32'(wr), 32'(e.wr));
          if (e.wr) begin
            chk("wb_addr", 32'(waddr), 32'(e.addr));
            chk("wb_data", 32'(wdata), 32'(e.data));
          end
          chk("wb_flags", 32'(flags), 32'(e.flags));
          chk("wb_latency", 32'(cyc), 32'(e.cyc));
        end
      end else if (wr) begin
        checks++;
        errors++;
        $display("FAIL stray_write: got o_rf_write=1 without o_done at cycle %0d, expected 0", cyc);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [2:0] d, input logic [2:0] s1,
                       input logic [2:0] s2, input logic [7:0] im, input logic ewr,
                       input logic [7:0] edata, input logic [2:0] eflags,
                       input bit keep_valid, input bit chk_gap);
    exp_t e;
    int   n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(ready), 32'd1);
    if (chk_gap) chk("burst_gap", 32'(cyc - last_acc), 32'd4);
    last_acc = cyc;
    opcode = op; rd = d; rs1 = s1; rs2 = s2; imm = im; valid = 1'b1;
    e.wr = ewr; e.addr = d; e.data = edata; e.flags = eflags; e.cyc = cyc + 3;
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
    chk("read_addr1", 32'(raddr1), 32'(s1));
    chk("read_addr2", 32'(raddr2), 32'(s2));
    chk("busy_not_ready", 32'(ready), 32'd0);
    if (keep_valid) begin
      // Would clobber r2 if the stage wrongly accepted it while busy.
      opcode = OP_ADD; rd = 3'd2; rs1 = 3'd1; rs2 = 3'd1; imm = 8'hAA;
    end else begin
      valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; rf_load = 1'b1;
    opcode = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_write", 32'(wr), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wdata", 32'(wdata), 32'd0);
    chk("rst_raddr1", 32'(raddr1), 32'd0);
    rf_load = 1'b0;
    rst = 1'b0;

    //     op       rd    rs1   rs2   imm    wr    data   {N,C,Z}
    issue(OP_ADD,  3'd3, 3'd1, 3'd2, 8'h00, 1'b1, 8'h80, 3'b100, 0, 0);
    issue(OP_SUB,  3'd4, 3'd2, 3'd1, 8'h00, 1'b1, 8'h82, 3'b110, 0, 0);
    issue(OP_CMP,  3'd0, 3'd1, 3'd1, 8'h00, 1'b0, 8'h00, 3'b001, 0, 0);
    issue(OP_LDI,  3'd5, 3'd0, 3'd0, 8'h80, 1'b1, 8'h80, 3'b001, 0, 0);
    issue(OP_SHL,  3'd6, 3'd5, 3'd0, 8'h00, 1'b1, 8'h00, 3'b011, 0, 0);
    issue(4'd12,   3'd7, 3'd1, 3'd2, 8'h00, 1'b0, 8'h00, 3'b011, 0, 0);
    drain();

    // i_valid held high for three back-to-back instructions
    issue(OP_AND,  3'd7, 3'd1, 3'd2, 8'h00, 1'b1, 8'h01, 3'b000, 1, 0);
    issue(OP_OR,   3'd0, 3'd1, 3'd4, 8'h00, 1'b1, 8'hFF, 3'b100, 1, 1);
    issue(OP_XOR,  3'd3, 3'd3, 3'd1, 8'h00, 1'b1, 8'hFF, 3'b100, 0, 1);
    drain();
    chk("rf_r3_xor", 32'(rf[3]), 32'h0000_00FF);
    chk("rf_r2_intact", 32'(rf[2]), 32'h0000_0001);

    // Reset during EXEC of ADD r2=r1+r1: must abort with no write-back
    opcode = OP_ADD; rd = 3'd2; rs1 = 3'd1; rs2 = 3'd1; imm = 8'h00; valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_flags", 32'(flags), 32'd0);
    chk("abort_write", 32'(wr), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("abort_write_hold", 32'(wr), 32'd0);
    chk("abort_done_hold", 32'(done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    issue(OP_ADD,  3'd3, 3'd1, 3'd2, 8'h00, 1'b1, 8'h80, 3'b100, 0, 0);
    drain();
    repeat (4) @(negedge clk);
    chk("abort_r2_unwritten", 32'(rf[2]), 32'h0000_0001);
    chk("post_reset_r3", 32'(rf[3]), 32'h0000_0080);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion by 200000, expected $finish earlier");
    $fatal(1, "timeout");
  end

endmodule
